// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Front-end producer for the decode stage. It generates
//               sequential fetch PCs and issues instruction-memory reads, with
//               at most one read outstanding at a time. Returned words are
//               buffered in a circular FIFO. The FIFO head is presented to
//               decode as an if_id_stage_reg_t. A redirect flushes the front
//               end and restarts fetch at a new PC. This includes a redirect
//               that arrives while a read is still in flight; the reply to
//               that read is drained and then dropped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   1    clock, rising edge
//   rst_n             in   1    asynchronous active-low reset
//   stall             in   1    decode cannot accept; no pop this cycle
//   redirect_valid    in   1    flush and restart fetch at redirect_pc
//   redirect_pc       in   32   new fetch PC (bits [1:0] forced to zero)
//   redirect_order    in   64   order of the first instruction after redirect
//   imem_addr         out  32   word-aligned read address
//   imem_rmask        out  4    4'hF while a read is requested, else 4'h0
//   imem_rdata        in   32   instruction word, valid with imem_resp
//   imem_resp         in   1    read complete
//   decode_struct_out out  129  FIFO head: {inst, pc, order, valid}
// ============================================================================

typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid;
} if_id_stage_reg_t;

module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic [63:0]      redirect_order,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    output if_id_stage_reg_t decode_struct_out
);

    localparam int                  c_PTR_W  = $clog2(DEPTH);
    localparam int                  c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_1  = c_PTR_W'(1);
    localparam logic [31:0]         c_WORD   = 32'd4;
    localparam logic [31:0]         c_ALIGN  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               state_q,    state_d;
    logic [31:0]          pc_q,       pc_d;
    logic [31:0]          req_addr_q, req_addr_d;
    logic [63:0]          order_q,    order_d;
    logic [c_PTR_W-1:0]   head_q,     head_d;
    logic [c_PTR_W-1:0]   tail_q,     tail_d;
    logic [c_CNT_W-1:0]   count_q,    count_d;
    logic [3:0]           rmask_q,    rmask_d;

    // FIFO payload storage; occupancy is tracked by head/tail/count, so the
    // storage itself needs no reset.
    logic [31:0]          inst_mem_q [DEPTH];
    logic [31:0]          pc_mem_q   [DEPTH];

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_valid;
    logic w_pop;
    logic w_push;

    assign w_empty = (count_q == '0);
    // A redirect hides the head in the same cycle, so decode never consumes
    // an instruction from the path being flushed.
    assign w_valid = !w_empty && !redirect_valid;
    assign w_pop   = w_valid && !stall;
    // Only a reply to a live request is kept; replies in DISCARD are stale.
    assign w_push  = (state_q == S_WAIT) && imem_resp && !redirect_valid;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        order_d    = order_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = redirect_pc & c_ALIGN;
            order_d = redirect_order;
            unique case (state_q)
                // A read still in flight must be drained before a new one
                // can be issued, because the memory answers in order.
                S_WAIT:    state_d = imem_resp ? S_IDLE : S_DISCARD;
                // A stale reply landing with a second redirect still ends the
                // drain; waiting for another reply here would never finish.
                S_DISCARD: state_d = imem_resp ? S_IDLE : S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end else begin
            if (w_pop) begin
                head_d  = head_q + c_PTR_1;
                order_d = order_q + 64'd1;
            end
            if (w_push) begin
                tail_d = tail_q + c_PTR_1;
            end
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

            unique case (state_q)
                S_IDLE: begin
                    if (count_d < c_DEPTH) begin
                        state_d    = S_WAIT;
                        req_addr_d = pc_q;
                    end
                end
                S_WAIT: begin
                    if (imem_resp) begin
                        pc_d = req_addr_q + c_WORD;
                        // Issuing the next request only while a slot is free
                        // guarantees that a push can never overflow the FIFO.
                        if (count_d < c_DEPTH) begin
                            req_addr_d = req_addr_q + c_WORD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (imem_resp) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        rmask_d = (state_d != S_IDLE) ? 4'hF : 4'h0;
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            order_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rmask_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            order_q    <= order_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rmask_q    <= rmask_d;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            inst_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]   <= req_addr_q;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_addr  = req_addr_q;
    assign imem_rmask = rmask_q;

    always_comb begin
        decode_struct_out       = '0;
        decode_struct_out.valid = w_valid;
        decode_struct_out.order = order_q;
        // The head fields read as zero when empty, so stale payload is never
        // visible on the decode interface.
        if (!w_empty) begin
            decode_struct_out.inst = inst_mem_q[head_q];
            decode_struct_out.pc   = pc_mem_q[head_q];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A memory responder with
//               programmable latency feeds the DUT. A queue-based reference
//               model tracks the expected decode head, the order number and
//               the next fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic         clk;
    logic         rst_n;
    logic         stall;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [63:0]  redirect_order;
    logic [31:0]  imem_addr;
    logic [3:0]   imem_rmask;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    logic [128:0] dso;   // {inst[128:97], pc[96:65], order[64:1], valid[0]}

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_order    (redirect_order),
        .imem_addr         (imem_addr),
        .imem_rmask        (imem_rmask),
        .imem_rdata        (imem_rdata),
        .imem_resp         (imem_resp),
        .decode_struct_out (dso)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_order;
    logic [31:0] m_fetch_pc;
    bit          busy;
    bit          discard;
    logic [31:0] busy_addr;
    int          cnt;
    int          mem_lat;        // -1 selects a random latency of 0..3
    int          pushes;
    int          pops;
    logic [31:0] pop_pc_log[$];
    logic [63:0] pop_ord_log[$];
    logic [31:0] req_log[$];
    bit          last_started;
    bit          pp_event;
    logic [31:0] trig_addr;

    int vectors;
    int miscompares;

    task automatic model_reset();
        q.delete();
        pop_pc_log.delete();
        pop_ord_log.delete();
        req_log.delete();
        m_order      = '0;
        m_fetch_pc   = RESET_PC;
        busy         = 1'b0;
        discard      = 1'b0;
        pushes       = 0;
        pops         = 0;
        last_started = 1'b0;
        pp_event     = 1'b0;
    endtask

    // One clock cycle. The memory responder runs first, then the inputs are
    // driven, then outputs are compared with the model, and the model advances.
    // rmode: 0 none, 1 redirect now, 2 redirect when request to trig_addr
    // starts, 3 redirect when a reply lands with a non-empty queue.
    task automatic cycle(input bit stl, input bit unstall_full, input int rmode,
                         input logic [31:0] rpc, input logic [63:0] rord,
                         output bit fired);
        bit          resp;
        bit          st;
        bit          rv;
        bit          started;
        bit          exp_valid;
        logic [31:0] rd;
        ent_t        e;
        @(negedge clk);
        started = 1'b0;
        resp    = 1'b0;
        if (busy) begin
            vectors++;
            if (imem_rmask !== 4'hF || imem_addr !== busy_addr) begin
                miscompares++;
                $display("FAIL held_req: rmask=%h addr=%h, expected rmask=f addr=%h", imem_rmask, imem_addr, busy_addr);
            end
        end else if (imem_rmask === 4'hF) begin
            busy      = 1'b1;
            busy_addr = imem_addr;
            cnt       = (mem_lat < 0) ? int'($urandom_range(3, 0)) : mem_lat;
            started   = 1'b1;
            req_log.push_back(imem_addr);
            vectors++;
            if (imem_addr !== m_fetch_pc) begin
                miscompares++;
                $display("FAIL req_addr: got %h, expected %h", imem_addr, m_fetch_pc);
            end
        end else begin
            vectors++;
            if (imem_rmask !== 4'h0) begin
                miscompares++;
                $display("FAIL rmask_idle: got %h, expected 0", imem_rmask);
            end
        end
        if (busy) begin
            if (cnt == 0) resp = 1'b1;
            else cnt--;
        end
        rd = $urandom;
        st = stl;
        if (unstall_full && resp && !discard && q.size() == DEPTH - 1) st = 1'b0;
        rv = (rmode == 1) || (rmode == 2 && started && imem_addr == trig_addr) ||
             (rmode == 3 && resp && q.size() != 0);
        fired = rv;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        redirect_order = rord;
        imem_resp      = resp;
        imem_rdata     = rd;
        #1;
        exp_valid = (q.size() != 0) && !rv;
        vectors++;
        if (dso[0] !== exp_valid) begin
            miscompares++;
            $display("FAIL valid: got %b, expected %b", dso[0], exp_valid);
        end
        vectors++;
        if (dso[64:1] !== m_order) begin
            miscompares++;
            $display("FAIL order: got %0d, expected %0d", dso[64:1], m_order);
        end
        if (exp_valid) begin
            vectors++;
            if (dso[128:97] !== q[0].inst || dso[96:65] !== q[0].pc) begin
                miscompares++;
                $display("FAIL head: got inst=%h pc=%h, expected inst=%h pc=%h", dso[128:97], dso[96:65], q[0].inst, q[0].pc);
            end
        end else if (q.size() == 0) begin
            vectors++;
            if (dso[128:65] !== 64'd0) begin
                miscompares++;
                $display("FAIL empty_head: got %h, expected 0", dso[128:65]);
            end
        end
        // advance model to the next clock edge
        if (rv) begin
            q.delete();
            m_order    = rord;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
            if (busy) begin
                if (resp) begin
                    busy    = 1'b0;
                    discard = 1'b0;
                end else begin
                    discard = 1'b1;
                end
            end
        end else begin
            if (exp_valid && !st) begin
                pop_pc_log.push_back(q[0].pc);
                pop_ord_log.push_back(m_order);
                void'(q.pop_front());
                m_order++;
                pops++;
            end
            if (resp) begin
                busy = 1'b0;
                if (discard) begin
                    discard = 1'b0;
                end else begin
                    vectors++;
                    if (q.size() >= DEPTH) begin
                        miscompares++;
                        $display("FAIL overflow: got occupancy %0d before push, expected < %0d", q.size(), DEPTH);
                    end
                    e.inst = rd;
                    e.pc   = busy_addr;
                    q.push_back(e);
                    m_fetch_pc = busy_addr + 32'd4;
                    pushes++;
                    if (st != stl) pp_event = 1'b1;
                end
            end
        end
        last_started = started;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        redirect_order = '0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit f;
        rst_n = 1'b1;
        #2;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        redirect_order = '0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        model_reset();
        mem_lat = 1;
        #11;
        vectors++;
        if (imem_rmask !== 4'h0 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_imem: got rmask=%h addr=%h, expected 0 %h", imem_rmask, imem_addr, RESET_PC);
        end
        vectors++;
        if (dso !== 129'd0) begin
            miscompares++;
            $display("FAIL reset_decode: got %h, expected 0", dso);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (imem_rmask !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_no_early_req: got %h, expected 0", imem_rmask);
        end
        cycle(1'b0, 1'b0, 0, '0, '0, f);
        vectors++;
        if (!last_started) begin
            miscompares++;
            $display("FAIL reset_first_req: got rmask=%h, expected f", imem_rmask);
        end
    endtask

    task automatic test_sequential();
        bit f;
        do_reset();
        mem_lat = 1;
        repeat (12) cycle(1'b0, 1'b0, 0, '0, '0, f);
        vectors++;
        if (pop_pc_log.size() < 3 || req_log.size() < 3) begin
            miscompares++;
            $display("FAIL seq_count: got pops=%0d reqs=%0d, expected >=3", pop_pc_log.size(), req_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (req_log[i] !== RESET_PC + 32'(4 * i) || pop_pc_log[i] !== RESET_PC + 32'(4 * i) ||
                    pop_ord_log[i] !== 64'(i)) begin
                    miscompares++;
                    $display("FAIL seq_%0d: got req=%h pc=%h order=%0d, expected %h %h %0d", i, req_log[i],
                             pop_pc_log[i], pop_ord_log[i], RESET_PC + 32'(4 * i), RESET_PC + 32'(4 * i), i);
                end
            end
        end
    endtask

    task automatic test_stall_fill();
        bit f;
        do_reset();
        mem_lat = 1;
        repeat (40) cycle(1'b1, 1'b0, 0, '0, '0, f);
        vectors++;
        if (pushes !== DEPTH || imem_rmask !== 4'h0 || dso[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: got pushes=%0d rmask=%h valid=%b, expected %0d 0 1", pushes, imem_rmask, dso[0], DEPTH);
        end
        mem_lat = -1;
        repeat (60) cycle(1'b0, 1'b0, 0, '0, '0, f);
        vectors++;
        if (pops < DEPTH + 4) begin
            miscompares++;
            $display("FAIL drain_pops: got %0d, expected >= %0d", pops, DEPTH + 4);
        end
        for (int i = 0; i < pop_pc_log.size(); i++) begin
            vectors++;
            if (pop_pc_log[i] !== RESET_PC + 32'(4 * i) || pop_ord_log[i] !== 64'(i)) begin
                miscompares++;
                $display("FAIL drain_contig_%0d: got pc=%h order=%0d, expected %h %0d", i, pop_pc_log[i],
                         pop_ord_log[i], RESET_PC + 32'(4 * i), i);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        bit f;
        int base_req;
        int base_pop;
        do_reset();
        mem_lat   = 3;
        trig_addr = 32'h1eceb00c;
        f         = 1'b0;
        for (int i = 0; i < 60 && !f; i++) cycle(1'b0, 1'b0, 2, 32'h1eceb100, 64'd40, f);
        vectors++;
        if (!f) begin
            miscompares++;
            $display("FAIL redir_trigger: got no request to %h, expected one", trig_addr);
        end
        base_req = req_log.size();
        base_pop = pop_pc_log.size();
        for (int i = 0; i < 10 && discard; i++) begin
            cycle(1'b0, 1'b0, 0, '0, '0, f);
            vectors++;
            if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb00c) begin
                miscompares++;
                $display("FAIL redir_stale_hold: got rmask=%h addr=%h, expected f 1eceb00c", imem_rmask, imem_addr);
            end
        end
        vectors++;
        if (discard) begin
            miscompares++;
            $display("FAIL redir_drain: got stale read still pending, expected drained");
        end
        mem_lat = 1;
        repeat (15) cycle(1'b0, 1'b0, 0, '0, '0, f);
        vectors++;
        if (req_log.size() <= base_req || pop_pc_log.size() <= base_pop) begin
            miscompares++;
            $display("FAIL redir_restart: got reqs=%0d pops=%0d, expected progress", req_log.size() - base_req, pop_pc_log.size() - base_pop);
        end else if (req_log[base_req] !== 32'h1eceb100 || pop_pc_log[base_pop] !== 32'h1eceb100 ||
                     pop_ord_log[base_pop] !== 64'd40) begin
            miscompares++;
            $display("FAIL redir_restart: got req=%h pc=%h order=%0d, expected 1eceb100 1eceb100 40",
                     req_log[base_req], pop_pc_log[base_pop], pop_ord_log[base_pop]);
        end
    endtask

    task automatic test_redirect_with_resp();
        bit f;
        int base_req;
        do_reset();
        mem_lat = 1;
        f       = 1'b0;
        for (int i = 0; i < 40 && !f; i++) cycle(1'b1, 1'b0, 3, 32'h0000_2002, 64'h123, f);
        vectors++;
        if (!f || dso[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_resp_cycle: got fired=%b valid=%b, expected 1 0", f, dso[0]);
        end
        base_req = req_log.size();
        cycle(1'b1, 1'b0, 0, '0, '0, f);
        vectors++;
        if (dso[0] !== 1'b0 || dso[64:1] !== 64'h123) begin
            miscompares++;
            $display("FAIL redir_resp_empty: got valid=%b order=%h, expected 0 123", dso[0], dso[64:1]);
        end
        repeat (6) cycle(1'b1, 1'b0, 0, '0, '0, f);
        vectors++;
        if (req_log.size() <= base_req) begin
            miscompares++;
            $display("FAIL redir_resp_next: got no new request, expected one to 00002000");
        end else if (req_log[base_req] !== 32'h0000_2000) begin
            miscompares++;
            $display("FAIL redir_resp_next: got %h, expected 00002000", req_log[base_req]);
        end
    endtask

    task automatic test_push_pop_full();
        bit f;
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 60 && !pp_event; i++) cycle(1'b1, 1'b1, 0, '0, '0, f);
        vectors++;
        if (!pp_event) begin
            miscompares++;
            $display("FAIL pushpop_reach: got no push+pop at %0d entries, expected one", DEPTH - 1);
        end
        cycle(1'b1, 1'b0, 0, '0, '0, f);
        vectors++;
        if (!last_started || imem_rmask !== 4'hF || dso[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pushpop_wait: got rmask=%h valid=%b, expected f 1", imem_rmask, dso[0]);
        end
    endtask

    task automatic test_async_reset_mid_wait();
        bit f;
        bit hit;
        do_reset();
        mem_lat = 2;
        hit     = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle(1'b1, 1'b0, 0, '0, '0, f);
            hit = (q.size() == DEPTH - 1) && busy;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL areset_setup: got occupancy %0d busy=%b, expected %0d 1", q.size(), busy, DEPTH - 1);
        end
        #2;
        rst_n     = 1'b0;
        imem_resp = 1'b0;
        #1;
        vectors++;
        if (imem_rmask !== 4'h0 || imem_addr !== RESET_PC || dso !== 129'd0) begin
            miscompares++;
            $display("FAIL areset_async: got rmask=%h addr=%h dso=%h, expected 0 %h 0", imem_rmask, imem_addr, dso, RESET_PC);
        end
        model_reset();
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 0, '0, '0, f);
        repeat (8) cycle(1'b0, 1'b0, 0, '0, '0, f);
        vectors++;
        if (req_log.size() == 0 || pop_pc_log.size() == 0) begin
            miscompares++;
            $display("FAIL areset_restart: got reqs=%0d pops=%0d, expected progress", req_log.size(), pop_pc_log.size());
        end else if (req_log[0] !== RESET_PC || pop_ord_log[0] !== 64'd0) begin
            miscompares++;
            $display("FAIL areset_restart: got req=%h order=%0d, expected %h 0", req_log[0], pop_ord_log[0], RESET_PC);
        end
    endtask

    task automatic test_random();
        bit f;
        bit st;
        bit rv;
        do_reset();
        mem_lat = -1;
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(2, 0) == 0);
            rv = ($urandom_range(39, 0) == 0);
            cycle(st, 1'b0, rv ? 1 : 0, $urandom, {$urandom, $urandom}, f);
        end
        vectors++;
        if (pushes < 100) begin
            miscompares++;
            $display("FAIL random_progress: got %0d pushes, expected >= 100", pushes);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        test_reset();
        test_sequential();
        test_stall_fill();
        test_redirect_inflight();
        test_redirect_with_resp();
        test_push_pop_full();
        test_async_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
